// File: rtl/cdc_handshake_rx_if.sv
// Bundles the 4-phase REQ/ACK crossing bus with the receive-side valid/ready port.
// slave: receiver end; master: sender and downstream consumer end.
interface cdc_handshake_rx_if #(
   parameter int unsigned DATA_W = 8
);
   logic              REQ_ASYNC;
   logic [DATA_W-1:0] DATA_ASYNC;
   logic              ACK;
   logic [DATA_W-1:0] OUT_DATA;
   logic              OUT_VALID;
   logic              OUT_READY;
   logic              BUSY;
   logic              ERR;

   modport slave (
      input  REQ_ASYNC, DATA_ASYNC, OUT_READY,
      output ACK, OUT_DATA, OUT_VALID, BUSY, ERR
   );

   modport master (
      output REQ_ASYNC, DATA_ASYNC, OUT_READY,
      input  ACK, OUT_DATA, OUT_VALID, BUSY, ERR
   );
endinterface

// File: rtl/cdc_handshake_rx.sv
// Receive side of a 4-phase REQ/ACK crossing: synchronises REQ, captures the held bus,
// hands it downstream over valid/ready and sequences ACK. Optional macro: CDC_RX_TIMEOUT_EN.
module cdc_handshake_rx #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SYNC_STAGES = 3,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                CLK,
   input  logic                RST,
   cdc_handshake_rx_if.slave   bus
);

   localparam int unsigned CNT_W = 16;

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
      $error("cdc_handshake_rx: SYNC_STAGES must be 2..4");
   end
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout_cyc
      $error("cdc_handshake_rx: TIMEOUT_CYC must be 1..65535");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_DELIVER,
      S_ACK_WAIT
`ifdef CDC_RX_TIMEOUT_EN
      , S_ERROR
`endif
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   ack_q, ack_d;
   logic                   valid_q, valid_d;
   logic [DATA_W-1:0]      data_q, data_d;
   logic                   busy_q, busy_d;
   logic                   req_s;

`ifdef CDC_RX_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   // Only REQ is synchronised; DATA_ASYNC is held stable by the sender while req_s=1.
   assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.REQ_ASYNC};
   assign req_s  = sync_q[SYNC_STAGES-1];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         sync_q  <= '0;
         ack_q   <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
`ifdef CDC_RX_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         ack_q   <= ack_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
`ifdef CDC_RX_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      valid_d = valid_q;
      data_d  = data_q;
`ifdef CDC_RX_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            ack_d   = 1'b0;
            valid_d = 1'b0;
            if (req_s) begin
               data_d  = bus.DATA_ASYNC;
               valid_d = 1'b1;
               state_d = S_DELIVER;
            end
         end
         S_DELIVER: begin
            if (bus.OUT_READY) begin
               valid_d = 1'b0;
               ack_d   = 1'b1;
               state_d = S_ACK_WAIT;
`ifdef CDC_RX_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         S_ACK_WAIT: begin
            ack_d = 1'b1;
            if (!req_s) begin
               ack_d   = 1'b0;
               state_d = S_IDLE;
            end
`ifdef CDC_RX_TIMEOUT_EN
            // cnt_q counts edges already spent in ACK_WAIT; this edge is the TIMEOUT_CYC-th.
            else if (cnt_q == TIMEOUT_LAST) begin
               err_d   = 1'b1;
               ack_d   = 1'b0;
               state_d = S_ERROR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
`ifdef CDC_RX_TIMEOUT_EN
         S_ERROR: begin
            ack_d = 1'b0;
            if (!req_s) begin
               state_d = S_IDLE;
            end
         end
`endif
         default: begin
            ack_d   = 1'b0;
            valid_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   assign bus.ACK       = ack_q;
   assign bus.OUT_VALID = valid_q;
   assign bus.OUT_DATA  = data_q;
   assign bus.BUSY      = busy_q;
`ifdef CDC_RX_TIMEOUT_EN
   assign bus.ERR       = err_q;
`else
   assign bus.ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Directed bench for cdc_handshake_rx (DATA_W=8, SYNC_STAGES=3, TIMEOUT_CYC=20).
// Timeout scenario runs only when CDC_RX_TIMEOUT_EN is defined.
module tb_cdc_handshake_rx;

   logic CLK;
   logic RST;
   int   n_checks;
   int   n_fail;
   int   n_valid;
   logic [7:0] got_data [0:7];

   cdc_handshake_rx_if #(.DATA_W(8)) bus ();

   cdc_handshake_rx #(
      .DATA_W      (8),
      .SYNC_STAGES (3),
      .TIMEOUT_CYC (20)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one CLK edge and park on the following falling edge for sampling/driving.
   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Full handshake with downstream ready; records every OUT_VALID cycle seen.
   task automatic run_xfer(input logic [7:0] d);
      bit seen;
      bus.REQ_ASYNC  = 1'b1;
      bus.DATA_ASYNC = d;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick();
         if (bus.OUT_VALID) begin
            if (n_valid < 8) got_data[n_valid] = bus.OUT_DATA;
            n_valid++;
         end
         if (bus.ACK) seen = 1'b1;
      end
      chk("xfer_ack_rise", 32'(bus.ACK), 32'd1);
      bus.REQ_ASYNC = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick();
         if (bus.OUT_VALID) n_valid++;
         if (!bus.ACK) seen = 1'b1;
      end
      chk("xfer_ack_fall", 32'(bus.ACK), 32'd0);
      tick();
      chk("xfer_busy_idle", 32'(bus.BUSY), 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      n_valid  = 0;
      RST            = 1'b1;
      bus.REQ_ASYNC  = 1'b0;
      bus.DATA_ASYNC = 8'h00;
      bus.OUT_READY  = 1'b0;
      #2;
      chk("rst_ack",   32'(bus.ACK),       32'd0);
      chk("rst_valid", 32'(bus.OUT_VALID), 32'd0);
      chk("rst_data",  32'(bus.OUT_DATA),  32'd0);
      chk("rst_busy",  32'(bus.BUSY),      32'd0);
      chk("rst_err",   32'(bus.ERR),       32'd0);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      ticks(2);

      // Basic transfer: valid on 4th edge counting the first REQ-sampling edge.
      bus.OUT_READY  = 1'b1;
      bus.REQ_ASYNC  = 1'b1;
      bus.DATA_ASYNC = 8'hA5;
      ticks(3);
      chk("basic_valid_early", 32'(bus.OUT_VALID), 32'd0);
      chk("basic_busy_early",  32'(bus.BUSY),      32'd0);
      tick();
      chk("basic_valid", 32'(bus.OUT_VALID), 32'd1);
      chk("basic_data",  32'(bus.OUT_DATA),  32'hA5);
      chk("basic_ack0",  32'(bus.ACK),       32'd0);
      chk("basic_busy",  32'(bus.BUSY),      32'd1);
      tick();
      chk("basic_valid_1cyc", 32'(bus.OUT_VALID), 32'd0);
      chk("basic_ack1",       32'(bus.ACK),       32'd1);
      bus.REQ_ASYNC = 1'b0;
      ticks(3);
      chk("basic_ack_hold", 32'(bus.ACK), 32'd1);
      tick();
      chk("basic_ack_fall", 32'(bus.ACK),      32'd0);
      chk("basic_busy_end", 32'(bus.BUSY),     32'd0);
      chk("basic_data_ret", 32'(bus.OUT_DATA), 32'hA5);
      ticks(3);

      // Backpressure: valid/data held for 10 cycles, ACK only after READY.
      bus.OUT_READY  = 1'b0;
      bus.REQ_ASYNC  = 1'b1;
      bus.DATA_ASYNC = 8'h3C;
      ticks(4);
      chk("bp_valid", 32'(bus.OUT_VALID), 32'd1);
      chk("bp_data",  32'(bus.OUT_DATA),  32'h3C);
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("bp_hold_valid", 32'(bus.OUT_VALID), 32'd1);
         chk("bp_hold_data",  32'(bus.OUT_DATA),  32'h3C);
         chk("bp_hold_ack",   32'(bus.ACK),       32'd0);
      end
      bus.OUT_READY = 1'b1;
      tick();
      chk("bp_valid_drop", 32'(bus.OUT_VALID), 32'd0);
      chk("bp_ack",        32'(bus.ACK),       32'd1);
      bus.REQ_ASYNC = 1'b0;
      ticks(4);
      chk("bp_ack_fall", 32'(bus.ACK),  32'd0);
      chk("bp_busy_end", 32'(bus.BUSY), 32'd0);
      ticks(3);

      // Back-to-back: three handshakes, exactly three pulses in order.
      n_valid = 0;
      run_xfer(8'h01);
      ticks(3);
      run_xfer(8'h02);
      ticks(3);
      run_xfer(8'h03);
      chk("b2b_count", 32'(n_valid), 32'd3);
      chk("b2b_d0", 32'(got_data[0]), 32'h01);
      chk("b2b_d1", 32'(got_data[1]), 32'h02);
      chk("b2b_d2", 32'(got_data[2]), 32'h03);
      ticks(3);

      // Reset while in DELIVER (ACK=0).
      bus.OUT_READY  = 1'b0;
      bus.REQ_ASYNC  = 1'b1;
      bus.DATA_ASYNC = 8'h5A;
      ticks(4);
      chk("rdel_pre_valid", 32'(bus.OUT_VALID), 32'd1);
      RST = 1'b1;
      bus.REQ_ASYNC = 1'b0;
      #1;
      chk("rdel_valid", 32'(bus.OUT_VALID), 32'd0);
      chk("rdel_data",  32'(bus.OUT_DATA),  32'd0);
      chk("rdel_busy",  32'(bus.BUSY),      32'd0);
      chk("rdel_ack",   32'(bus.ACK),       32'd0);
      tick();
      RST = 1'b0;
      ticks(2);

      // Reset while in ACK_WAIT (ACK=1).
      bus.OUT_READY  = 1'b1;
      bus.REQ_ASYNC  = 1'b1;
      bus.DATA_ASYNC = 8'hC3;
      ticks(5);
      chk("rack_pre_ack", 32'(bus.ACK), 32'd1);
      RST = 1'b1;
      bus.REQ_ASYNC = 1'b0;
      #1;
      chk("rack_ack",   32'(bus.ACK),       32'd0);
      chk("rack_busy",  32'(bus.BUSY),      32'd0);
      chk("rack_data",  32'(bus.OUT_DATA),  32'd0);
      chk("rack_valid", 32'(bus.OUT_VALID), 32'd0);
      tick();
      RST = 1'b0;
      ticks(2);
      n_valid = 0;
      run_xfer(8'h77);
      chk("rst_fresh_count", 32'(n_valid),     32'd1);
      chk("rst_fresh_data",  32'(got_data[0]), 32'h77);
      ticks(3);

      // REQ dropped during DELIVER: single delivery, 1-cycle ACK pulse.
      bus.OUT_READY  = 1'b0;
      bus.REQ_ASYNC  = 1'b1;
      bus.DATA_ASYNC = 8'h96;
      ticks(4);
      chk("early_valid", 32'(bus.OUT_VALID), 32'd1);
      ticks(2);
      bus.REQ_ASYNC = 1'b0;
      ticks(3);
      chk("early_hold_valid", 32'(bus.OUT_VALID), 32'd1);
      chk("early_hold_data",  32'(bus.OUT_DATA),  32'h96);
      bus.OUT_READY = 1'b1;
      tick();
      chk("early_ack_pulse", 32'(bus.ACK),       32'd1);
      chk("early_valid_off", 32'(bus.OUT_VALID), 32'd0);
      tick();
      chk("early_ack_off", 32'(bus.ACK),  32'd0);
      chk("early_idle",    32'(bus.BUSY), 32'd0);
      n_valid = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.OUT_VALID) n_valid++;
      end
      chk("early_no_redeliver", 32'(n_valid), 32'd0);

`ifdef CDC_RX_TIMEOUT_EN
      // Watchdog: ACK drops and ERR sets 20 edges after ACK_WAIT entry.
      bus.OUT_READY  = 1'b1;
      bus.REQ_ASYNC  = 1'b1;
      bus.DATA_ASYNC = 8'hE1;
      ticks(5);
      chk("to_ack_entry", 32'(bus.ACK), 32'd1);
      ticks(19);
      chk("to_ack_before", 32'(bus.ACK), 32'd1);
      chk("to_err_before", 32'(bus.ERR), 32'd0);
      tick();
      chk("to_ack_drop", 32'(bus.ACK),  32'd0);
      chk("to_err_set",  32'(bus.ERR),  32'd1);
      chk("to_busy",     32'(bus.BUSY), 32'd1);
      n_valid = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.OUT_VALID) n_valid++;
      end
      chk("to_no_recapture", 32'(n_valid),  32'd0);
      chk("to_err_busy",     32'(bus.BUSY), 32'd1);
      bus.REQ_ASYNC = 1'b0;
      ticks(4);
      chk("to_busy_clear", 32'(bus.BUSY), 32'd0);
      ticks(2);
      n_valid = 0;
      run_xfer(8'h4B);
      chk("to_next_count", 32'(n_valid),     32'd1);
      chk("to_next_data",  32'(got_data[0]), 32'h4B);
      chk("to_err_sticky", 32'(bus.ERR),     32'd1);
`else
      chk("err_tied_low", 32'(bus.ERR), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Hard stop in case a wait above never resolves.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cdc_handshake_rx.md
Name: cdc_handshake_rx

Overview:
Receive-side controller for a 4-phase REQ/ACK clock-domain crossing. It synchronises an asynchronous request through an internal multi-flop synchroniser chain and captures a multi-bit bus that the sender holds stable. It presents the captured word on a valid/ready interface in the CLK domain, then sequences ACK back to the sender. It sits at every multi-bit asynchronous entry point, alongside the single-bit synchronisers.

Parameters:
DATA_W, 8, width of the crossing data bus
SYNC_STAGES, 3, flops in the REQ synchroniser chain; legal range 2..4
TIMEOUT_CYC, 255, ACK_WAIT watchdog limit in CLK cycles; used only with CDC_RX_TIMEOUT_EN; legal range 1..65535

Ports:
CLK  in  1  receive-domain clock
RST  in  1  reset, asynchronous, active-high
REQ_ASYNC  in  1  sender request, asynchronous to CLK
DATA_ASYNC  in  DATA_W  sender data; stable from REQ rise until ACK seen high
ACK  out  1  acknowledge to sender, registered
OUT_DATA  out  DATA_W  captured word
OUT_VALID  out  1  OUT_DATA valid
OUT_READY  in  1  downstream accepts OUT_DATA
BUSY  out  1  1 whenever state != IDLE
ERR  out  1  sticky timeout flag; constant 0 without CDC_RX_TIMEOUT_EN

Behaviour:
- RST=1: all synchroniser flops, state, ACK, OUT_VALID, OUT_DATA and ERR go to 0 immediately. State goes to IDLE.
- RST mid-transfer: the pending word is dropped and ACK falls at once. The sender must restart the handshake.
- req_s is REQ_ASYNC passed through SYNC_STAGES flops in series, each reset to 0. DATA_ASYNC is never synchronised; it is sampled only when req_s=1.
- IDLE: ACK=0, OUT_VALID=0.
  - At a CLK edge with req_s=1: OUT_DATA<=DATA_ASYNC, OUT_VALID<=1, state->DELIVER.
- DELIVER: OUT_DATA and OUT_VALID are held stable.
  - At a CLK edge with OUT_READY=1: OUT_VALID<=0, ACK<=1, state->ACK_WAIT.
  - OUT_READY already high when OUT_VALID rises: accepted at the first DELIVER edge, so OUT_VALID lasts exactly 1 cycle.
- ACK_WAIT: ACK held at 1.
  - At a CLK edge with req_s=0: ACK<=0, state->IDLE.
- Latency, REQ rise to OUT_VALID: SYNC_STAGES+1 edges after the first edge that samples REQ high.
- Latency, OUT_VALID&&OUT_READY to ACK: 1 edge.
- Latency, REQ fall to ACK fall: SYNC_STAGES+1 edges.
- Back-to-back transfers: a new capture starts only after IDLE sees req_s=1 again. With the sender obeying 4-phase, this is at least SYNC_STAGES cycles after ACK falls.
- Protocol violations are not flagged; the required behaviour is:
  - REQ pulse shorter than 1 CLK period: may be missed.
  - REQ falls in DELIVER: the word is still delivered. ACK pulses for 1 cycle, because ACK_WAIT sees req_s=0 on its first edge.
  - DATA_ASYNC changes while req_s=1 in IDLE: the value at the capture edge is taken.
- OUT_DATA retains the last captured word after OUT_VALID falls.

Optional Feature:
CDC_RX_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on ACK_WAIT entry and increments each cycle in ACK_WAIT.
  - When it reaches TIMEOUT_CYC with req_s still 1: ERR<=1 (sticky until RST), ACK<=0, state->ERROR.
  - ERROR: ACK=0, BUSY=1, no capture. On req_s=0: state->IDLE.
  - ERR stays set and does not block later transfers.
- Undefined: no counter and no ERROR state. ERR is tied to 0. ACK_WAIT waits indefinitely.

Test Plan:
- Basic transfer: DATA_W=8, OUT_READY=1. Raise REQ with DATA_ASYNC=0xA5, then drop REQ after ACK is seen.
  -> OUT_VALID=1 for 1 cycle with OUT_DATA=0xA5, 4 edges after REQ is first sampled. ACK rises 1 edge later and falls 4 edges after REQ falls. BUSY returns to 0.
- Backpressure: OUT_READY=0 for 10 cycles after OUT_VALID rises, with DATA_ASYNC=0x3C.
  -> OUT_VALID and OUT_DATA=0x3C held for 10 cycles. ACK stays 0 until the edge after OUT_READY=1.
- Back-to-back: three full handshakes with 0x01, 0x02, 0x03, downstream always ready.
  -> exactly 3 OUT_VALID pulses, in order, with no duplicates.
- Reset mid-operation: assert RST while in DELIVER with ACK=0, and again while in ACK_WAIT with ACK=1.
  -> ACK, OUT_VALID, OUT_DATA and BUSY go to 0 in the same cycle without waiting for a clock edge. A fresh handshake after release completes normally.
- REQ early drop: drop REQ 2 cycles after OUT_VALID rises, with OUT_READY=0 and released 5 cycles later.
  -> the word is delivered once. ACK is a 1-cycle pulse. State returns to IDLE.
- Timeout (CDC_RX_TIMEOUT_EN, TIMEOUT_CYC=20): hold REQ high after ACK rises.
  -> ERR=1 and ACK=0 exactly 20 cycles after ACK_WAIT entry. No recapture while REQ is high. After REQ falls, BUSY=0, and the next transfer succeeds with ERR still 1.
